matrix_key_scanner: RTL and testbench

MATRIX_KEY_SCANNER -- requirements
Module: matrix_key_scanner

---
 rtl/matrix_key_scanner.sv | 208 ++++++++++++++++++++
 tb/tb_matrix_key_scanner.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_key_scanner.sv
// 4x4 keypad scanner: column drive, 2-flop row sync, debounce and hold
// tracking, one valid pulse per accepted press.
module matrix_key_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] shift_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0] REL_LAST = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    row_s1_q, row_s1_d;
    logic [3:0]    rs_q, rs_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    pat_q, pat_d;
    logic [1:0]    ridx_q, ridx_d;
    logic [1:0]    cidx_q, cidx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rel_q, rel_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic       tick;
    logic       one_zero;
    logic [3:0] rs_n;
    logic [1:0] rs_ridx;
    logic [1:0] col_cidx;
    logic [3:0] col_rot;

    function automatic logic [3:0] key_lut(input logic [1:0] r,
                                           input logic [1:0] c);
        logic [3:0] k;
        unique case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'hE;
            4'hD: k = 4'h0;
            4'hE: k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    always_comb begin
        tick     = (div_q == DIV_LAST);
        rs_n     = ~rs_q;
        one_zero = (rs_n != 4'h0) && ((rs_n & (rs_n - 4'h1)) == 4'h0);
        col_rot  = {col_q[2:0], col_q[3]};
        unique case (rs_q)
            4'b1101: rs_ridx = 2'd1;
            4'b1011: rs_ridx = 2'd2;
            4'b0111: rs_ridx = 2'd3;
            default: rs_ridx = 2'd0;
        endcase
        unique case (col_q)
            4'b1101: col_cidx = 2'd1;
            4'b1011: col_cidx = 2'd2;
            4'b0111: col_cidx = 2'd3;
            default: col_cidx = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= SCAN;
            row_s1_q    <= 4'hF;
            rs_q        <= 4'hF;
            div_q       <= '0;
            col_q       <= 4'b1110;
            pat_q       <= 4'hF;
            ridx_q      <= '0;
            cidx_q      <= '0;
            cnt_q       <= '0;
            rel_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_s1_q    <= row_s1_d;
            rs_q        <= rs_d;
            div_q       <= div_d;
            col_q       <= col_d;
            pat_q       <= pat_d;
            ridx_q      <= ridx_d;
            cidx_q      <= cidx_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SCAN: begin
                if (tick && one_zero)
                    state_d = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (cnt_q == CNT_MAX)
                    state_d = HELD;
                else if (tick && rs_q != pat_q)
                    state_d = SCAN;
            end
            HELD: begin
                if (tick && rs_q == 4'hF && rel_q == REL_LAST)
                    state_d = SCAN;
            end
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        row_s1_d    = row;
        rs_d        = row_s1_q;
        div_d       = tick ? '0 : div_q + 1'b1;
        col_d       = col_q;
        pat_d       = pat_q;
        ridx_d      = ridx_q;
        cidx_d      = cidx_q;
        cnt_d       = cnt_q;
        rel_d       = rel_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        unique case (state_q)
            SCAN: begin
                if (tick) begin
                    if (one_zero) begin
                        pat_d  = rs_q;
                        ridx_d = rs_ridx;
                        cidx_d = col_cidx;
                        cnt_d  = CW'(1);
                    end else begin
                        col_d = col_rot;
                    end
                end
            end
            DEBOUNCE: begin
                if (cnt_q == CNT_MAX) begin
                    key_code_d  = key_lut(ridx_q, cidx_q);
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    rel_d       = '0;
                end else if (tick) begin
                    if (rs_q == pat_q)
                        cnt_d = cnt_q + 1'b1;
                    else
                        col_d = col_rot;
                end
            end
            HELD: begin
                // Column stays frozen; only an all-released row re-arms.
                if (tick) begin
                    if (rs_q != 4'hF) begin
                        rel_d = '0;
                    end else if (rel_q == REL_LAST) begin
                        key_held_d = 1'b0;
                        col_d      = 4'b1110;
                        div_d      = '0;
                        rel_d      = '0;
                    end else begin
                        rel_d = rel_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        shift_col = col_q;
        key_code  = key_code_q;
        key_valid = key_valid_q;
        key_held  = key_held_q;
    end
endmodule

// File: tb/tb_matrix_key_scanner.sv
// Bench for matrix_key_scanner: keypad model, per-cycle reference model,
// directed scenarios and random key activity.
module tb_matrix_key_scanner;
    localparam int SDIV = 4;
    localparam int DCNT = 3;

    logic       clk;
    logic       reset;
    logic [3:0] row;
    logic [3:0] shift_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys;
    int n_tests;
    int n_fail;
    int pulses;

    int kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    matrix_key_scanner #(
        .SCAN_DIV(SDIV),
        .DEBOUNCE_CNT(DCNT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .row(row),
        .shift_col(shift_col),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && shift_col[c] == 1'b0)
                    row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 scanning, 1 confirming, 2 waiting for release.
    int m_mode, m_div, m_col, m_cnt, m_rel, m_cand, m_code;
    logic [3:0] m_s1, m_rs, m_pat;
    logic m_valid, m_held;

    always @(posedge clk) begin
        bit tk;
        int ri;
        if (!reset) begin
            m_mode = 0; m_div = 0; m_col = 0; m_cnt = 0; m_rel = 0;
            m_code = 0; m_valid = 0; m_held = 0;
            m_s1 = 4'hF; m_rs = 4'hF; m_pat = 4'hF; m_cand = 0;
        end else begin
            tk = (m_div == SDIV - 1);
            m_div = (m_div + 1) % SDIV;
            m_valid = 0;
            case (m_mode)
                0: if (tk) begin
                    if ($countones(~m_rs) == 1) begin
                        ri = 0;
                        for (int i = 0; i < 4; i++)
                            if (m_rs[i] == 1'b0) ri = i;
                        m_pat = m_rs;
                        m_cand = kmap[ri*4+m_col];
                        m_cnt = 1;
                        m_mode = 1;
                    end else begin
                        m_col = (m_col + 1) % 4;
                    end
                end
                1: if (m_cnt == DCNT) begin
                    m_mode = 2; m_valid = 1; m_code = m_cand;
                    m_held = 1; m_rel = 0;
                end else if (tk) begin
                    if (m_rs == m_pat) begin
                        if (m_cnt < DCNT) m_cnt++;
                    end else begin
                        m_mode = 0;
                        m_col = (m_col + 1) % 4;
                    end
                end
                default: if (tk) begin
                    if (m_rs == 4'hF) begin
                        m_rel++;
                        if (m_rel == DCNT) begin
                            m_mode = 0; m_held = 0; m_col = 0;
                            m_div = 0; m_rel = 0;
                        end
                    end else begin
                        m_rel = 0;
                    end
                end
            endcase
            m_rs = m_s1;
            m_s1 = row;
        end
    end

    always @(negedge clk) begin
        logic [3:0] ec;
        ec = ~(4'b0001 << m_col);
        check("model shift_col", 32'(shift_col), 32'(ec));
        check("model key_valid", 32'(key_valid), 32'(m_valid));
        check("model key_held", 32'(key_held), 32'(m_held));
        check("model key_code", 32'(key_code), 32'(m_code));
        if (key_valid === 1'b1) pulses++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int lat;
        int changes;
        logic [3:0] prev;
        logic [3:0] ec;
        n_tests = 0; n_fail = 0; pulses = 0;
        keys = '0;
        reset = 1'b0;
        wait_cyc(3);
        check("reset shift_col", 32'(shift_col), 32'hE);
        check("reset key_valid", 32'(key_valid), 32'h0);
        check("reset key_held", 32'(key_held), 32'h0);
        check("reset key_code", 32'(key_code), 32'h0);

        // Idle column walk, 4 cycles per column.
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            ec = ~(4'b0001 << ((k / 4) % 4));
            check("wrap shift_col", 32'(shift_col), 32'(ec));
            wait_cyc(1);
        end

        // Clean press of key 6 with latency bound.
        p0 = pulses;
        keys[6] = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            wait_cyc(1);
            if (lat < 0 && pulses != p0) lat = k;
        end
        check("press6 pulses", 32'(pulses - p0), 32'd1);
        check("press6 code", 32'(key_code), 32'h6);
        check("press6 held", 32'(key_held), 32'h1);
        check("press6 latency ok", 32'(lat > 0 && lat <= 31), 32'd1);
        keys[6] = 1'b0;
        wait_cyc(2);
        check("release6 still held", 32'(key_held), 32'h1);
        wait_cyc(20);
        check("release6 held", 32'(key_held), 32'h0);
        check("release6 code kept", 32'(key_code), 32'h6);

        // Bouncing key 8, then stable.
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            keys[9] = (i % 2 == 0);
            wait_cyc(SDIV);
        end
        check("bounce8 no pulse", 32'(pulses - p0), 32'd0);
        keys[9] = 1'b1;
        wait_cyc(50);
        check("bounce8 pulses", 32'(pulses - p0), 32'd1);
        check("bounce8 code", 32'(key_code), 32'h8);
        keys[9] = 1'b0;
        wait_cyc(30);

        // Two rows low in column 1: ghost, keep scanning.
        p0 = pulses;
        keys[1] = 1'b1;
        keys[13] = 1'b1;
        changes = 0;
        prev = shift_col;
        for (int k = 0; k < 40; k++) begin
            wait_cyc(1);
            if (shift_col != prev) changes++;
            prev = shift_col;
        end
        check("multi no pulse", 32'(pulses - p0), 32'd0);
        check("multi rotating", 32'(changes >= 8), 32'd1);
        keys = '0;
        wait_cyc(10);

        // Rollover F then 0.
        p0 = pulses;
        keys[14] = 1'b1;
        wait_cyc(40);
        check("rollF pulses", 32'(pulses - p0), 32'd1);
        check("rollF code", 32'(key_code), 32'hF);
        keys[13] = 1'b1;
        wait_cyc(30);
        check("roll0 no pulse", 32'(pulses - p0), 32'd1);
        check("roll0 held", 32'(key_held), 32'h1);
        keys[14] = 1'b0;
        wait_cyc(4);
        keys[13] = 1'b0;
        wait_cyc(30);
        check("roll released pulses", 32'(pulses - p0), 32'd1);
        check("roll released held", 32'(key_held), 32'h0);
        check("roll code kept", 32'(key_code), 32'hF);
        keys[13] = 1'b1;
        wait_cyc(40);
        check("roll0 repress pulses", 32'(pulses - p0), 32'd2);
        check("roll0 repress code", 32'(key_code), 32'h0);
        keys = '0;
        wait_cyc(30);

        // Reset while A is held, then re-detect.
        p0 = pulses;
        keys[3] = 1'b1;
        wait_cyc(45);
        check("holdA pulses", 32'(pulses - p0), 32'd1);
        check("holdA code", 32'(key_code), 32'hA);
        reset = 1'b0;
        wait_cyc(1);
        reset = 1'b1;
        check("rstA shift_col", 32'(shift_col), 32'hE);
        check("rstA held", 32'(key_held), 32'h0);
        check("rstA valid", 32'(key_valid), 32'h0);
        wait_cyc(45);
        check("rstA redetect pulses", 32'(pulses - p0), 32'd2);
        check("rstA redetect code", 32'(key_code), 32'hA);
        keys = '0;
        wait_cyc(30);

        // Random key activity against the model.
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) keys[$urandom_range(0, 15)] ^= 1'b1;
            else if (r < 8) keys = '0;
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b0;
                wait_cyc(1);
                reset = 1'b1;
            end
            wait_cyc($urandom_range(1, 60));
        end
        keys = '0;
        wait_cyc(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
